// File: rtl/edge_event_monitor.sv
// edge_event_monitor: samples four 8-bit channels every cycle and queues
// one timestamped event per cycle in which any channel changed.
// Ports: clk, rst (sync, active-high); ch_a..ch_d monitored inputs;
// evt_valid/evt_ready pop handshake; evt_mask, evt_a..evt_d, evt_time
// give the FIFO head (zero when empty); overflow is sticky, clr_ovf clears.
module edge_event_monitor #(
   parameter int DEPTH = 8,
   parameter int TS_W  = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      ch_a,
   input  logic [7:0]      ch_b,
   input  logic [7:0]      ch_c,
   input  logic [7:0]      ch_d,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [3:0]      evt_mask,
   output logic [7:0]      evt_a,
   output logic [7:0]      evt_b,
   output logic [7:0]      evt_c,
   output logic [7:0]      evt_d,
   output logic [TS_W-1:0] evt_time,
   output logic            overflow,
   input  logic            clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = TS_W + 4 + 32;

   logic [TS_W-1:0] r_cnt;
   logic [31:0]     r_smp;
   logic [31:0]     r_prev;
   logic [TS_W-1:0] r_ts;
   logic            r_ev_v;
   logic [EW-1:0]   r_ev_word;
   logic [EW-1:0]   r_mem [DEPTH];
   logic [AW:0]     r_wr;
   logic [AW:0]     r_rd;
   logic            r_ovf;

   logic [31:0]     w_in;
   logic [3:0]      w_mask;
   logic            w_full;
   logic            w_empty;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;
   logic [EW-1:0]   w_head;

   assign w_in = {ch_d, ch_c, ch_b, ch_a};

   always_comb begin
      w_mask = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         w_mask[i] = (r_smp[8*i +: 8] != r_prev[8*i +: 8]);
      end
   end

   // Full: same slot index, opposite wrap bit.
   assign w_empty = (r_wr == r_rd);
   assign w_full  = (r_wr[AW] != r_rd[AW]) &&
                    (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop   = !w_empty && evt_ready;
   // A pop frees a slot in the same edge, so full+pop still accepts.
   assign w_push  = r_ev_v && (!w_full || w_pop);
   assign w_drop  = r_ev_v && w_full && !w_pop;

   // Sample, change-detect and event-register stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_smp     <= w_in;
         r_prev    <= w_in;
         r_ts      <= '0;
         r_ev_v    <= 1'b0;
         r_ev_word <= '0;
      end else begin
         r_cnt     <= r_cnt + {{(TS_W-1){1'b0}}, 1'b1};
         r_smp     <= w_in;
         r_prev    <= r_smp;
         r_ts      <= r_cnt;
         r_ev_v    <= (w_mask != 4'b0000);
         r_ev_word <= {r_ts, w_mask, r_smp};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr <= r_wr + {{AW{1'b0}}, 1'b1};
         end
         if (w_pop) begin
            r_rd <= r_rd + {{AW{1'b0}}, 1'b1};
         end
         // A drop in the same cycle as clr_ovf keeps the flag set.
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (clr_ovf) begin
            r_ovf <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_mem[r_wr[AW-1:0]] <= r_ev_word;
      end
   end

   assign w_head    = r_mem[r_rd[AW-1:0]];
   assign evt_valid = !w_empty;
   assign overflow  = r_ovf;

   always_comb begin
      {evt_time, evt_mask, evt_d, evt_c, evt_b, evt_a} = '0;
      if (!w_empty) begin
         {evt_time, evt_mask, evt_d, evt_c, evt_b, evt_a} = w_head;
      end
   end

endmodule

// File: tb/tb_edge_event_monitor.sv
// Bench for edge_event_monitor: directed channel changes, with a queue of
// expected events checked by a monitor on every pop.
module tb_edge_event_monitor;

   localparam int DEPTH = 8;
   localparam int TS_W  = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [7:0]      ch_a = 8'h00;
   logic [7:0]      ch_b = 8'h00;
   logic [7:0]      ch_c = 8'h00;
   logic [7:0]      ch_d = 8'h00;
   logic            evt_valid;
   logic            evt_ready = 1'b0;
   logic [3:0]      evt_mask;
   logic [7:0]      evt_a;
   logic [7:0]      evt_b;
   logic [7:0]      evt_c;
   logic [7:0]      evt_d;
   logic [TS_W-1:0] evt_time;
   logic            overflow;
   logic            clr_ovf = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   logic [51:0]     q[$];
   logic [15:0]     m_cnt;

   edge_event_monitor #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .ch_a      (ch_a),
      .ch_b      (ch_b),
      .ch_c      (ch_c),
      .ch_d      (ch_d),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_mask  (evt_mask),
      .evt_a     (evt_a),
      .evt_b     (evt_b),
      .evt_c     (evt_c),
      .evt_d     (evt_d),
      .evt_time  (evt_time),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   always #5 clk = ~clk;

   // Cycle count since reset release: the timestamp an edge should stamp.
   always @(posedge clk) begin
      if (rst) m_cnt <= '0;
      else     m_cnt <= m_cnt + 16'd1;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   // Drive new channel values; keep=1 means the event must come out.
   task automatic chg(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d,
                      input logic [3:0] m, input bit keep);
      ch_a = a; ch_b = b; ch_c = c; ch_d = d;
      if (keep) q.push_back({m_cnt, m, d, c, b, a});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [7:0] a);
      rst = 1'b1;
      ch_a = a; ch_b = 8'h00; ch_c = 8'h00; ch_d = 8'h00;
      q.delete();
      repeat (3) step();
      chk("rst_valid", evt_valid, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_out", {evt_time, evt_mask, evt_a}, 0);
      rst = 1'b0;
   endtask

   // Monitor: every accepted head must match the next expected event.
   always @(negedge clk) begin
      if (!rst) begin
         if (evt_valid && evt_ready) begin
            if (q.size() == 0) begin
               chk("pop_unexpected", 1, 0);
            end else begin
               chk("pop_evt",
                   {evt_time, evt_mask, evt_d, evt_c, evt_b, evt_a},
                   q.pop_front());
            end
         end else if (!evt_valid) begin
            chk("idle_zero",
                {evt_time, evt_mask, evt_d, evt_c, evt_b, evt_a}, 0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      bit seen;

      // Nonzero input across reset release, then steady.
      do_reset(8'h05);
      seen = 1'b0;
      repeat (20) begin
         step();
         if (evt_valid || overflow) seen = 1'b1;
      end
      chk("steady_noevt", seen, 1'b0);

      // Latency and timestamp: ch_a at edge 5, ch_b/ch_c at edge 6.
      do_reset(8'h00);
      repeat (5) step();
      chg(8'd5, 8'd0, 8'd0, 8'd0, 4'b0001, 1'b1);
      step();
      chk("lat_e5", evt_valid, 1'b0);
      chg(8'd5, 8'd10, 8'd15, 8'd0, 4'b0110, 1'b1);
      step();
      chk("lat_e6", evt_valid, 1'b0);
      step();
      chk("lat_e7", evt_valid, 1'b1);
      chk("e1_mask", evt_mask, 4'b0001);
      chk("e1_a", evt_a, 8'd5);
      chk("e1_time", evt_time, 16'd5);
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      repeat (3) begin
         chk("e2_valid", evt_valid, 1'b1);
         chk("e2_mask", evt_mask, 4'b0110);
         chk("e2_bc", {evt_b, evt_c}, {8'd10, 8'd15});
         chk("e2_time", evt_time, 16'd6);
         step();
      end
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      step();
      chk("e2_drained", evt_valid, 1'b0);
      chk("e2_q", q.size(), 0);

      // Overflow: DEPTH+2 changes, last two dropped.
      for (int i = 1; i <= DEPTH + 2; i++) begin
         chg(8'd5, 8'd10, 8'd15, 8'(i), 4'b1000, i <= DEPTH);
         step();
      end
      repeat (4) step();
      chk("ovf_set", overflow, 1'b1);
      chk("ovf_valid", evt_valid, 1'b1);
      evt_ready = 1'b1;
      repeat (DEPTH + 2) step();
      evt_ready = 1'b0;
      chk("ovf_drained", evt_valid, 1'b0);
      chk("ovf_q", q.size(), 0);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("ovf_clr", overflow, 1'b0);

      // Full FIFO, pop and push on the same edge.
      for (int i = 0; i < DEPTH; i++) begin
         chg(8'd5, 8'd10, 8'd15, 8'(20 + i), 4'b1000, 1'b1);
         step();
      end
      repeat (3) step();
      chk("full_noovf", overflow, 1'b0);
      chg(8'd5, 8'd10, 8'd15, 8'd99, 4'b1000, 1'b1);
      step();
      step();
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      repeat (2) step();
      chk("pp_noovf", overflow, 1'b0);
      evt_ready = 1'b1;
      repeat (DEPTH + 2) step();
      evt_ready = 1'b0;
      chk("pp_drained", evt_valid, 1'b0);
      chk("pp_q", q.size(), 0);

      // Mid-run reset discards queued events and restarts the counter.
      for (int i = 1; i <= 3; i++) begin
         chg(8'd5, 8'd10, 8'd15, 8'(i), 4'b1000, 1'b1);
         step();
      end
      repeat (4) step();
      chk("pre_rst_valid", evt_valid, 1'b1);
      rst = 1'b1;
      ch_d = 8'd77;
      q.delete();
      step();
      rst = 1'b0;
      chk("rst_flush", evt_valid, 1'b0);
      step();
      step();
      chk("rst_nostale", evt_valid, 1'b0);
      chg(8'd5, 8'd10, 8'd15, 8'd50, 4'b1000, 1'b1);
      step();
      step();
      chk("rst_lat_e3", evt_valid, 1'b0);
      step();
      chk("rst_lat_e4", evt_valid, 1'b1);
      chk("rst_time", evt_time, 16'd2);
      chk("rst_d", evt_d, 8'd50);
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      repeat (2) step();
      chk("end_valid", evt_valid, 1'b0);
      chk("end_q", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/edge_event_monitor.md
EDGE_EVENT_MONITOR -- requirements
Module: edge_event_monitor

Interface
REQ-001 Parameter DEPTH, default 8, event FIFO depth; SHALL be a power of two, minimum 2.
REQ-002 Parameter TS_W, default 16, timestamp width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 ch_a, ch_b, ch_c, ch_d  input  8 each  monitored channels; treated as asynchronous to nothing, sampled every cycle.
REQ-006 evt_valid  output  1  FIFO head holds an event.
REQ-007 evt_ready  input  1  consumer accepts head; pop occurs when evt_valid && evt_ready at a rising edge.
REQ-008 evt_mask  output  4  at head, bit0..bit3 = ch_a..ch_d changed.
REQ-009 evt_a, evt_b, evt_c, evt_d  output  8 each  at head, snapshot of all four channels.
REQ-010 evt_time  output  TS_W  at head, timestamp of the change.
REQ-011 overflow  output  1  sticky; an event was dropped because the FIFO was full.
REQ-012 clr_ovf  input  1  clears overflow.

Function
REQ-013 Free-running timestamp counter SHALL increment by 1 every cycle and wrap from 2^TS_W-1 to 0 without flag.
REQ-014 Input registers SHALL capture ch_a..ch_d every cycle (sample stage); a previous-sample register SHALL hold the prior sample.
REQ-015 Change detect: mask bit i = (sample_i != prev_i); an event SHALL be generated when mask != 0.
REQ-016 At most one event per cycle; multiple channels changing in the same cycle SHALL yield one event with several mask bits set.
REQ-017 Event word = {timestamp of the sample cycle, mask, current samples of all four channels}.
REQ-018 Latency: a change present at rising edge k SHALL appear as evt_valid=1 after edge k+2 when the FIFO was empty; evt_time = counter value captured at edge k.
REQ-019 evt_* outputs SHALL be driven from the FIFO head and be stable while evt_valid=1 and evt_ready=0.
REQ-020 evt_mask, evt_a..evt_d and evt_time SHALL be 0 when evt_valid=0.
REQ-021 FIFO: circular buffer, read/write pointers log2(DEPTH)+1 bits; full when pointers differ only in MSB; empty when equal; pointers wrap at DEPTH.
REQ-022 Full and push with no pop: event SHALL be dropped, FIFO contents unchanged, overflow set next cycle.
REQ-023 Full, push and pop in the same cycle: pop and push SHALL both complete, no drop, overflow unchanged.
REQ-024 Empty, push and evt_ready=1: the event SHALL NOT be popped that cycle (no fall-through); it appears next cycle.
REQ-025 clr_ovf and a drop in the same cycle: overflow SHALL remain 1 (set wins).
REQ-026 No events SHALL be generated while inputs are steady, regardless of their values.

Reset
REQ-027 While rst=1: counter=0, FIFO pointers=0, overflow=0, evt_valid=0, all evt_* outputs=0.
REQ-028 While rst=1 both the sample and previous-sample registers SHALL load the current inputs, so nonzero inputs at reset release produce no event.
REQ-029 Reset asserted mid-operation SHALL discard all queued events within one cycle; any change in the reset cycle is not reported.

Verification
REQ-030 Reset with ch_a=8'h05, others 0, release, hold steady 20 cycles -> evt_valid stays 0, overflow 0.
REQ-031 After reset release at counter 0, drive ch_a=5 at edge 5 -> evt_valid after edge 7, evt_mask=4'b0001, evt_a=5, evt_time=5.
REQ-032 At same edge set ch_b=10 and ch_c=15 -> single event, evt_mask=4'b0110, evt_b=10, evt_c=15; hold evt_ready=0 3 cycles, outputs stable.
REQ-033 evt_ready=0, change ch_d every cycle DEPTH+2 times -> DEPTH events queued, overflow=1; drain with evt_ready=1 -> DEPTH events in order with increasing evt_time, then evt_valid=0; pulse clr_ovf -> overflow=0.
REQ-034 FIFO full, evt_ready=1 and a new change same cycle -> count stays DEPTH, overflow stays 0, new event is last out.
REQ-035 Queue 3 events, assert rst one cycle -> evt_valid=0 next cycle, counter restarts at 0, no stale events after release.
